// File: rtl/dsp_pkg.sv
// Shared DSP definitions: OPMODE bit positions and encodings used by the
// add/subtract/accumulate datapath.
package dsp_pkg;

  // OPMODE bit positions
  localparam int OP_SUB = 0;
  localparam int OP_ACC = 1;

  localparam int OPMODE_W = 2;

  typedef enum logic [OPMODE_W-1:0] {
    OPM_ADD     = 2'b00,
    OPM_SUB     = 2'b01,
    OPM_ACC_ADD = 2'b10,
    OPM_ACC_SUB = 2'b11
  } opmode_e;

  function automatic logic is_sub(input logic [OPMODE_W-1:0] op);
    return op[OP_SUB];
  endfunction

  function automatic logic is_acc(input logic [OPMODE_W-1:0] op);
    return op[OP_ACC];
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH+1 bit add/subtract with unsigned carry/borrow out
// and two's-complement overflow detect.
module addsub_core #(
  parameter int WIDTH = 48
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] p,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0]          bc;
  logic [WIDTH:0]          ures;
  logic signed [WIDTH+1:0] xs;
  logic signed [WIDTH+1:0] bs;
  logic signed [WIDTH+1:0] sres;

  always_comb begin
    // B+CIN is formed one bit wider so that B=all-ones, CIN=1 does not wrap
    bc   = {1'b0, b} + {{WIDTH{1'b0}}, cin};
    ures = sub ? ({1'b0, x} - bc) : ({1'b0, x} + bc);

    xs   = {{2{x[WIDTH-1]}}, x};
    bs   = {{2{b[WIDTH-1]}}, b} + {{(WIDTH+1){1'b0}}, cin};
    sres = sub ? (xs - bs) : (xs + bs);

    p    = ures[WIDTH-1:0];
    cout = ures[WIDTH];
    // in range iff the top three bits of the wide signed result agree
    ovf  = (sres[WIDTH+1:WIDTH-1] != 3'b000) && (sres[WIDTH+1:WIDTH-1] != 3'b111);
  end

endmodule

// File: rtl/add_sub_acc.sv
// Pipelined add/subtract/accumulate: optional input register stage followed
// by the result registers P/COUT/OVF/out_valid, all gated by CE.
module add_sub_acc
  import dsp_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int INREG = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic [1:0]       OPMODE,
  output logic             out_valid,
  output logic [WIDTH-1:0] P,
  output logic             COUT,
  output logic             OVF
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("add_sub_acc: WIDTH must be in 2..64");
  end
  if (INREG != 0 && INREG != 1) begin : g_bad_inreg
    $error("add_sub_acc: INREG must be 0 or 1");
  end

  logic             s_valid;
  logic [WIDTH-1:0] s_a;
  logic [WIDTH-1:0] s_b;
  logic             s_cin;
  logic [1:0]       s_op;

  if (INREG == 1) begin : g_inreg
    always_ff @(posedge CLK) begin
      if (RST) begin
        s_valid <= 1'b0;
        s_a     <= '0;
        s_b     <= '0;
        s_cin   <= 1'b0;
        s_op    <= '0;
      end else if (CE) begin
        s_valid <= in_valid;
        s_a     <= A;
        s_b     <= B;
        s_cin   <= CIN;
        s_op    <= OPMODE;
      end
    end
  end else begin : g_noinreg
    assign s_valid = in_valid;
    assign s_a     = A;
    assign s_b     = B;
    assign s_cin   = CIN;
    assign s_op    = OPMODE;
  end

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] core_p;
  logic             core_cout;
  logic             core_ovf;

  // accumulate reads the live P register, so consecutive ops chain without a bubble
  assign x = is_acc(s_op) ? P : s_a;

  addsub_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .x    (x),
    .b    (s_b),
    .cin  (s_cin),
    .sub  (is_sub(s_op)),
    .p    (core_p),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      P         <= '0;
      COUT      <= 1'b0;
      OVF       <= 1'b0;
    end else if (CE) begin
      out_valid <= s_valid;
      if (s_valid) begin
        P    <= core_p;
        COUT <= core_cout;
        OVF  <= core_ovf;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_acc.sv
// Self-checking bench for add_sub_acc at WIDTH=18, INREG=1: directed vector
// table plus hand-written accumulate, stall and reset sequences.
module tb_add_sub_acc;

  localparam int W = 18;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CE;
  logic          in_valid;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          CIN;
  logic [1:0]    OPMODE;
  logic          out_valid;
  logic [W-1:0]  P;
  logic          COUT;
  logic          OVF;

  int errors = 0;
  int checks = 0;

  add_sub_acc #(
    .WIDTH(W),
    .INREG(1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CE        (CE),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
    .OPMODE    (OPMODE),
    .out_valid (out_valid),
    .P         (P),
    .COUT      (COUT),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [1:0]   op;
    logic [W-1:0] p;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [1:0] op);
    in_valid = v;
    A        = a;
    B        = b;
    CIN      = c;
    OPMODE   = op;
  endtask

  initial begin
    //          a          b         cin op     p          cout ovf
    vecs[0] = '{18'd100,   18'd23,   1'b1, 2'b00, 18'd124,   1'b0, 1'b0};
    vecs[1] = '{18'd5,     18'd7,    1'b0, 2'b01, 18'h3FFFE, 1'b1, 1'b0};
    vecs[2] = '{18'h1FFFF, 18'd1,    1'b0, 2'b00, 18'h20000, 1'b0, 1'b1};
    vecs[3] = '{18'h3FFFF, 18'd1,    1'b0, 2'b00, 18'h00000, 1'b1, 1'b0};
    vecs[4] = '{18'h20000, 18'd1,    1'b0, 2'b01, 18'h1FFFF, 1'b0, 1'b1};
    vecs[5] = '{18'd0,     18'd0,    1'b1, 2'b01, 18'h3FFFF, 1'b1, 1'b0};
    vecs[6] = '{18'h20000, 18'h20000,1'b0, 2'b00, 18'h00000, 1'b1, 1'b1};
    vecs[7] = '{18'd7,     18'h3FFFF,1'b1, 2'b01, 18'd7,     1'b1, 1'b0};
    vecs[8] = '{18'h3FFFF, 18'h3FFFF,1'b1, 2'b00, 18'h3FFFF, 1'b1, 1'b0};
    vecs[9] = '{18'h1FFFF, 18'd0,    1'b1, 2'b00, 18'h20000, 1'b0, 1'b1};

    RST = 1'b1;
    CE  = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 2'b00);
    tick();
    tick();
    RST = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_p",         64'(P),         64'd0);
    check("reset_cout",      64'(COUT),      64'd0);
    check("reset_ovf",       64'(OVF),       64'd0);

    // single operations: latency 2, one-cycle out_valid pulse, outputs hold after
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op);
      tick();
      drive(1'b0, 18'h15A5A, 18'h0A5A5, 1'b1, 2'b11);
      check($sformatf("vec%0d_early_valid", i), 64'(out_valid), 64'd0);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_p",     i), 64'(P),         64'(vecs[i].p));
      check($sformatf("vec%0d_cout",  i), 64'(COUT),      64'(vecs[i].cout));
      check($sformatf("vec%0d_ovf",   i), 64'(OVF),       64'(vecs[i].ovf));
      tick();
      check($sformatf("vec%0d_bubble_valid", i), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d_bubble_p",     i), 64'(P),         64'(vecs[i].p));
    end

    // accumulate from reset: B=10 four times back to back
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("acc_start_p", 64'(P), 64'd0);
    drive(1'b1, 18'd999, 18'd10, 1'b0, 2'b10);
    tick();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) in_valid = 1'b0;
      tick();
      check($sformatf("acc%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("acc%0d_p",     k), 64'(P),         64'(10 * k));
    end
    tick();
    check("acc_end_valid", 64'(out_valid), 64'd0);
    check("acc_end_p",     64'(P),         64'd40);
    // accumulate-subtract: 40 - (15 + 0) = 25
    drive(1'b1, 18'd999, 18'd15, 1'b0, 2'b11);
    tick();
    in_valid = 1'b0;
    tick();
    check("accsub_p",    64'(P),    64'd25);
    check("accsub_cout", 64'(COUT), 64'd0);

    // stall: op parked in stage 1 while CE=0 for 3 cycles
    drive(1'b1, 18'd50, 18'd8, 1'b0, 2'b00);
    tick();
    drive(1'b0, 18'd1, 18'd1, 1'b0, 2'b00);
    CE = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("stall%0d_valid", s), 64'(out_valid), 64'd0);
      check($sformatf("stall%0d_p",     s), 64'(P),         64'd25);
    end
    CE = 1'b1;
    tick();
    check("stall_release_valid", 64'(out_valid), 64'd1);
    check("stall_release_p",     64'(P),         64'd58);
    tick();
    check("stall_once_valid", 64'(out_valid), 64'd0);
    check("stall_once_p",     64'(P),         64'd58);

    // reset with an op in stage 1 and CE low: reset wins, op never emerges
    drive(1'b1, 18'd1000, 18'd1, 1'b0, 2'b00);
    tick();
    in_valid = 1'b0;
    CE  = 1'b0;
    RST = 1'b1;
    tick();
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_p",     64'(P),         64'd0);
    RST = 1'b0;
    CE  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick();
      check($sformatf("rst_after%0d_valid", r), 64'(out_valid), 64'd0);
      check($sformatf("rst_after%0d_p",     r), 64'(P),         64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_sub_acc.md
ADD_SUB_ACC -- requirements
Module: add_sub_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 48, meaning operand/result width; legal 2..64, other values fail elaboration.
REQ-002 SHALL have parameter INREG, default 1, meaning input register stage present (1) or bypassed (0); other values fail elaboration.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port CE  input  1  clock enable for every register in the block.
REQ-006 SHALL have port in_valid  input  1  operands on A/B/CIN/OPMODE are valid this cycle.
REQ-007 SHALL have port A  input  WIDTH  first operand.
REQ-008 SHALL have port B  input  WIDTH  second operand.
REQ-009 SHALL have port CIN  input  1  carry/borrow in.
REQ-010 SHALL have port OPMODE  input  2  bit0: 1=subtract, 0=add; bit1: 1=accumulate (use P instead of A).
REQ-011 SHALL have port out_valid  output  1  P/COUT/OVF carry a new result.
REQ-012 SHALL have port P  output  WIDTH  registered result.
REQ-013 SHALL have port COUT  output  1  registered carry out (add) / borrow out (subtract).
REQ-014 SHALL have port OVF  output  1  registered two's-complement overflow flag for the result.

Function
REQ-015 SHALL compute X = (OPMODE[1] ? P : A); add: {COUT,P} = X + B + CIN; subtract: {COUT,P} = X - (B + CIN), all in WIDTH+1 bits with B+CIN formed without wrap.
REQ-016 SHALL set COUT to bit WIDTH of the WIDTH+1-bit result (subtract: 1 = borrow); P SHALL be the low WIDTH bits (modulo wrap-around).
REQ-017 SHALL set OVF=1 iff the signed result (X, B sign-extended, CIN zero-extended) is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-018 SHALL register A, B, CIN, OPMODE, in_valid in stage 1 when INREG=1; result registers (P, COUT, OVF, out_valid) always present.
REQ-019 SHALL have latency INREG+1 cycles from in_valid sample to out_valid; throughput one operation per CE cycle.
REQ-020 SHALL, when CE=0, hold every register; no operation is lost or duplicated across a stall.
REQ-021 SHALL, when CE=1, load out_valid from the stage valid; SHALL update P/COUT/OVF only when that stage valid=1, otherwise hold them.
REQ-022 SHALL use the current P register as the accumulate operand, so back-to-back accumulate operations chain with no bubble.
REQ-023 SHALL take in_valid=0 with CE=1 as a bubble: out_valid falls, P/COUT/OVF hold.

Reset
REQ-024 SHALL, on RST=1 at a clock edge, clear P, COUT, OVF, out_valid and all stage-1 registers to 0, overriding CE.
REQ-025 SHALL discard any operation in flight when RST is asserted; it never appears at the outputs.
REQ-026 SHALL start accumulation from P=0 after reset.

Structure
REQ-027 SHALL take OPMODE bit positions/encodings (OP_SUB, OP_ACC) from the shared package dsp_pkg.
REQ-028 SHALL place the combinational WIDTH+1 add/subtract with overflow detect in one sub-module, addsub_core; registers stay in add_sub_acc.

Verification (WIDTH=18, INREG=1)
REQ-029 SHALL cover add: A=100, B=23, CIN=1, OPMODE=00 -> 2 cycles later P=124, COUT=0, OVF=0, out_valid=1 for one cycle.
REQ-030 SHALL cover borrow: A=5, B=7, CIN=0, OPMODE=01 -> P=0x3FFFE, COUT=1, OVF=0.
REQ-031 SHALL cover accumulate: after reset, four consecutive valid B=10, OPMODE=10 -> P=10, 20, 30, 40 on consecutive cycles.
REQ-032 SHALL cover overflow: A=0x1FFFF, B=1, OPMODE=00 -> P=0x20000, OVF=1, COUT=0.
REQ-033 SHALL cover stall: CE=0 for 3 cycles with one operation in stage 1 -> all outputs hold; result appears once, 1 cycle after CE returns.
REQ-034 SHALL cover reset mid-operation: RST=1 while an operation is in stage 1 -> next cycle out_valid=0, P=0; that operation never emerges.
